// File: rtl/subneg_pkg.sv
// Shared types and constants for the SUBNEG one-instruction core sequencer.
package subneg_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int INSTR_WORDS   = 3;

   typedef enum logic [2:0] {
      IDLE,
      FA,
      FB,
      FC,
      RA,
      RB,
      EX,
      HALT
   } state_e;

endpackage

// File: rtl/subneg_alu.sv
// Combinational SUBNEG datapath: res = minuend - subtrahend (mod 2^WIDTH), negative flag from MSB.
module subneg_alu #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] minuend_i,
   input  logic [WIDTH-1:0] subtrahend_i,
   output logic [WIDTH-1:0] res_o,
   output logic             neg_o
);

   assign res_o = minuend_i - subtrahend_i;
   assign neg_o = res_o[WIDTH-1];

endmodule

// File: rtl/subneg_ctrl.sv
// Fetch/execute sequencer for the SUBNEG core: fetches A/B/C from ROM, reads both operands,
// writes dmem[B]-dmem[A] back and branches to C on a negative result.
module subneg_ctrl
   import subneg_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] rom_addr,
   input  logic [WIDTH-1:0] rom_data,
   output logic [WIDTH-1:0] dmem_raddr,
   input  logic [WIDTH-1:0] dmem_rdata,
   output logic             dmem_we,
   output logic [WIDTH-1:0] dmem_waddr,
   output logic [WIDTH-1:0] dmem_wdata,
   output logic [WIDTH-1:0] pc,
   output logic             busy,
   output logic             halt
);

   state_e           state_q;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] c_q;
   logic [WIDTH-1:0] opA_q;
   logic [WIDTH-1:0] romAddr_q;
   logic [WIDTH-1:0] romAddr_d;
   logic [WIDTH-1:0] dmemRaddr_q;
   logic [WIDTH-1:0] dmemRaddr_d;
   logic [WIDTH-1:0] aluRes;
   logic             aluNeg;

   // In EX the second operand arrives straight from the memory, so the subtract is combinational.
   subneg_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .minuend_i    (dmem_rdata),
      .subtrahend_i (opA_q),
      .res_o        (aluRes),
      .neg_o        (aluNeg)
   );

   // Address ports are driven by the state that owns them and otherwise hold their last value.
   always_comb begin
      romAddr_d   = romAddr_q;
      dmemRaddr_d = dmemRaddr_q;
      case (state_q)
         IDLE, FA: romAddr_d   = pc_q;
         FB:       romAddr_d   = pc_q + WIDTH'(1);
         FC:       romAddr_d   = pc_q + WIDTH'(2);
         RA:       dmemRaddr_d = a_q;
         RB:       dmemRaddr_d = b_q;
         default:  ;
      endcase
   end

   // Reset forces every output quiet in the same cycle so an aborted EX never writes.
   assign rom_addr   = rst ? '0 : romAddr_d;
   assign dmem_raddr = rst ? '0 : dmemRaddr_d;
   assign dmem_we    = !rst && (state_q == EX);
   assign dmem_waddr = (!rst && (state_q == EX)) ? b_q : '0;
   assign dmem_wdata = (!rst && (state_q == EX)) ? aluRes : '0;
   assign pc         = pc_q;
   assign busy       = !rst && (state_q != IDLE) && (state_q != HALT);
   assign halt       = !rst && (state_q == HALT);

   // Sequencer: each ROM word is captured one cycle after its address was presented.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         opA_q       <= '0;
         romAddr_q   <= '0;
         dmemRaddr_q <= '0;
      end else begin
         romAddr_q   <= romAddr_d;
         dmemRaddr_q <= dmemRaddr_d;
         case (state_q)
            IDLE: begin
               if (start) state_q <= FA;
            end
            FA: state_q <= FB;
            FB: begin
               a_q     <= rom_data;
               state_q <= FC;
            end
            FC: begin
               b_q     <= rom_data;
               state_q <= RA;
            end
            RA: begin
               c_q     <= rom_data;
               state_q <= RB;
            end
            RB: begin
               opA_q   <= dmem_rdata;
               state_q <= EX;
            end
            EX: begin
               // A negative result that branches onto itself is the program's halt idiom.
               if (aluNeg && (c_q == pc_q)) begin
                  state_q <= HALT;
               end else if (aluNeg) begin
                  pc_q    <= c_q;
                  state_q <= FA;
               end else begin
                  pc_q    <= pc_q + WIDTH'(INSTR_WORDS);
                  state_q <= FA;
               end
            end
            HALT:    state_q <= HALT;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
